ps2_kbd_ctrl: RTL and testbench

Command sequencer and scancode buffer on the CPU side of the PS/2 `host` block. It takes one keyboard command (opcode plus optional argument byte) and drives it through the host's transmit interface. It waits for the keyboard's ACK (0xFA), retransmits on RESEND (0xFE) or a receive error, and enforces a response timeout. Every other byte received from the keyboard goes into a small scancode FIFO.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sc_fifo.sv | 80 ++++++++
 rtl/ps2_kbd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard command sequencer and scancode FIFO.
package ps2_pkg;

    // Keyboard response bytes
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    // Command result codes reported on err_code
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;

    // Width of the per-byte response timer and of a scancode
    localparam int TIMER_W = 20;
    localparam int SC_W    = 8;

    // Command sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ps2_sc_fifo.sv
// Scancode FIFO: registered head (no fall-through), push accepted when full
// only if a pop happens in the same cycle, sticky overflow flag.
module ps2_sc_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [SC_W-1:0] push_data,
    input  logic            pop,
    input  logic            ovf_clr,
    output logic            empty,
    output logic [SC_W-1:0] head,
    output logic            overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [SC_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW-1:0]   wptr_n, rptr_n;
    logic            full;
    logic            do_push, do_pop, drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign wptr_n  = wptr_q + PW'(do_push);
    assign rptr_n  = rptr_q + PW'(do_pop);

    // Storage write; entries need no reset because pointers gate their use
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_n;
            rptr_q <= rptr_n;
        end
    end

    // Head register tracks the entry at the post-update read pointer; the
    // bypass covers a push that lands as the only remaining entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (wptr_n != rptr_n) begin
            if (do_push && (wptr_q == rptr_n)) begin
                head <= push_data;
            end else begin
                head <= mem[rptr_n[AW-1:0]];
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command sequencer: sends opcode (and optional argument)
// through the host transmitter, waits for ACK, retries on RESEND/receive
// error, times out per byte, and buffers every other received byte.
//
// Handshake: a command transfers on the cycle where cmd_valid and cmd_ready
// are both high; cmd_valid may be held without ready and fields must be
// stable while it is. A scancode is popped on the cycle where sc_valid and
// sc_ready are both high.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_done,
    output logic [1:0] err_code,
    output logic       sc_valid,
    output logic [7:0] sc_data,
    input  logic       sc_ready,
    output logic       sc_overflow,
    input  logic       ovf_clr,
    output logic       rx_err,
    input  logic [7:0] host_rcv_data,
    input  logic       host_rcv_error,
    input  logic       host_rcv_strobe,
    input  logic       host_xmt_ready,
    output logic [7:0] host_xmt_data,
    output logic       host_xmt_strobe,
    output logic [1:0] dbg_state
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t             state_q, state_n;
    logic [7:0]         op_q, arg_q;
    logic               has_arg_q;
    logic               phase_q;
    logic [RW-1:0]      retry_q;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         err_q, err_n;

    logic load_cmd, load_timer, set_phase, retry_inc, retry_clr;
    logic fifo_push, fifo_empty;
    logic rcv_ok, rcv_bad, timer_zero;

    assign rcv_ok     = host_rcv_strobe && !host_rcv_error;
    assign rcv_bad    = host_rcv_strobe && host_rcv_error;
    assign timer_zero = (timer_q == '0);

    assign cmd_ready = (state_q == IDLE);
    assign cmd_done  = (state_q == DONE);
    assign err_code  = err_q;
    assign sc_valid  = !fifo_empty;
    assign dbg_state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, transmit drive, FIFO push and result selection
    always_comb begin
        state_n         = state_q;
        err_n           = err_q;
        load_cmd        = 1'b0;
        load_timer      = 1'b0;
        set_phase       = 1'b0;
        retry_inc       = 1'b0;
        retry_clr       = 1'b0;
        host_xmt_strobe = 1'b0;
        host_xmt_data   = 8'h00;
        rx_err          = rcv_bad;
        fifo_push       = rcv_ok;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load_cmd   = 1'b1;
                    load_timer = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: begin
                host_xmt_data   = phase_q ? arg_q : op_q;
                host_xmt_strobe = host_xmt_ready;
                if (host_xmt_ready) begin
                    state_n = WAIT;
                end else if (timer_zero) begin
                    state_n = DONE;
                    err_n   = ERR_TIMEOUT;
                end
            end
            WAIT: begin
                // ACK and RESEND are consumed here; everything else is buffered
                fifo_push = rcv_ok && (host_rcv_data != PS2_ACK) && (host_rcv_data != PS2_RESEND);
                if (host_rcv_strobe) begin
                    if (rcv_bad || (host_rcv_data == PS2_RESEND)) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_inc  = 1'b1;
                            load_timer = 1'b1;
                            state_n    = SEND;
                        end else begin
                            state_n = DONE;
                            err_n   = ERR_RETRY;
                        end
                    end else if (host_rcv_data == PS2_ACK) begin
                        if (!phase_q && has_arg_q) begin
                            set_phase  = 1'b1;
                            retry_clr  = 1'b1;
                            load_timer = 1'b1;
                            state_n    = SEND;
                        end else begin
                            state_n = DONE;
                            err_n   = ERR_OK;
                        end
                    end
                end else if (timer_zero) begin
                    state_n = DONE;
                    err_n   = ERR_TIMEOUT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Command latch, phase flag, retry counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 8'h00;
            arg_q     <= 8'h00;
            has_arg_q <= 1'b0;
            phase_q   <= 1'b0;
            retry_q   <= '0;
            err_q     <= ERR_OK;
        end else begin
            err_q <= err_n;
            if (load_cmd) begin
                op_q      <= cmd_data;
                arg_q     <= cmd_arg;
                has_arg_q <= cmd_has_arg;
                phase_q   <= 1'b0;
                retry_q   <= '0;
            end else begin
                if (set_phase) begin
                    phase_q <= 1'b1;
                end
                if (retry_clr) begin
                    retry_q <= '0;
                end else if (retry_inc) begin
                    retry_q <= retry_q + RW'(1);
                end
            end
        end
    end

    // Per-byte response timer: reloaded on every entry to SEND, counts down
    // through SEND and WAIT and parks at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (load_timer) begin
            timer_q <= TIMER_W'(TIMEOUT_CYCLES);
        end else if (((state_q == SEND) || (state_q == WAIT)) && !timer_zero) begin
            timer_q <= timer_q - TIMER_W'(1);
        end
    end

    ps2_sc_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(host_rcv_data),
        .pop      (sc_ready),
        .ovf_clr  (ovf_clr),
        .empty    (fifo_empty),
        .head     (sc_data),
        .overflow (sc_overflow)
    );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed command/FIFO/reset scenarios followed by
// randomized commands, keyboard responses and scancode traffic.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;
    import ps2_pkg::*;

    localparam int FD = 4;
    localparam int TO = 100;
    localparam int MR = 3;
    localparam int R_ERR = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0;
    logic [7:0] cmd_data = 8'h00, cmd_arg = 8'h00;
    logic       cmd_ready, cmd_done;
    logic [1:0] err_code;
    logic       sc_valid, sc_overflow;
    logic [7:0] sc_data;
    logic       sc_ready = 1'b0, ovf_clr = 1'b0;
    logic       rx_err;
    logic [7:0] host_rcv_data = 8'h00;
    logic       host_rcv_error = 1'b0, host_rcv_strobe = 1'b0;
    logic       host_xmt_ready = 1'b0;
    logic [7:0] host_xmt_data;
    logic       host_xmt_strobe;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    // Stimulus modes: ready_mode 0 low / 1 high / 2 random;
    // pop_mode 0 low / 1 random / 2 manual / 3 high
    int ready_mode = 0;
    int pop_mode = 0;
    bit ovf_rand = 0;
    bit chk_en = 0;
    bit tb_push = 0;
    bit prev_strobe = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];      // expected scancode FIFO contents
    bit         m_ovf = 0;     // expected overflow flag
    logic [7:0] xmt_exp_q[$];  // expected transmitted bytes for a command
    logic [1:0] exp_err;
    int         resp_q[$];     // keyboard reply per strobe: byte, R_ERR, or -1 silent

    ps2_kbd_ctrl #(
        .FIFO_DEPTH(FD),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
        .cmd_done(cmd_done), .err_code(err_code),
        .sc_valid(sc_valid), .sc_data(sc_data), .sc_ready(sc_ready),
        .sc_overflow(sc_overflow), .ovf_clr(ovf_clr), .rx_err(rx_err),
        .host_rcv_data(host_rcv_data), .host_rcv_error(host_rcv_error),
        .host_rcv_strobe(host_rcv_strobe), .host_xmt_ready(host_xmt_ready),
        .host_xmt_data(host_xmt_data), .host_xmt_strobe(host_xmt_strobe),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Background drivers for transmitter ready, scancode pop and overflow clear
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: host_xmt_ready = 1'b0;
            1: host_xmt_ready = 1'b1;
            default: host_xmt_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (pop_mode)
            0: sc_ready = 1'b0;
            1: sc_ready = 1'($urandom_range(0, 1));
            3: sc_ready = 1'b1;
            default: ;
        endcase
        if (ovf_rand) ovf_clr = ($urandom_range(0, 15) == 0);
    end

    // Scancode FIFO reference: a queue of at most FD bytes
    initial forever begin
        bit ovf_ev;
        @(posedge clk or negedge rst_n);
        ovf_ev = 0;
        if (!rst_n) begin
            exp_q.delete();
            m_ovf = 0;
        end else begin
            if (sc_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (host_rcv_strobe && tb_push) begin
                if (exp_q.size() < FD) exp_q.push_back(host_rcv_data);
                else ovf_ev = 1;
            end
            if (ovf_ev) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Per-cycle compare against the reference and the protocol rules
    initial forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
            chk("sc_valid", sc_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) chk("sc_data", sc_data, exp_q[0]);
            chk("sc_overflow", sc_overflow, m_ovf);
            chk("rx_err", rx_err, host_rcv_strobe && host_rcv_error);
            chk("strobe_without_ready", host_xmt_strobe && !host_xmt_ready, 0);
            chk("strobe_back_to_back", host_xmt_strobe && prev_strobe, 0);
            chk("ready_and_done", cmd_ready && cmd_done, 0);
            prev_strobe = host_xmt_strobe;
            if (cmd_done) done_cnt++;
        end else begin
            prev_strobe = 0;
        end
    end

    // Command-level reference: bytes the keyboard must see and the result
    function automatic void model_cmd(input logic [7:0] op, input bit has_arg, input logic [7:0] arg);
        int ph, rt, r;
        ph = 0;
        rt = 0;
        xmt_exp_q.delete();
        exp_err = ERR_TIMEOUT;
        if (ready_mode == 0) return;
        for (int i = 0; i < 64; i++) begin
            xmt_exp_q.push_back(ph ? arg : op);
            r = (i < resp_q.size()) ? resp_q[i] : -1;
            if (r < 0) begin
                exp_err = ERR_TIMEOUT;
                return;
            end else if (r == R_ERR || r == 32'hFE) begin
                if (rt < MR) rt++;
                else begin
                    exp_err = ERR_RETRY;
                    return;
                end
            end else begin
                if (ph == 0 && has_arg) begin
                    ph = 1;
                    rt = 0;
                end else begin
                    exp_err = ERR_OK;
                    return;
                end
            end
        end
    endfunction

    function automatic logic [7:0] pick_sc();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (b == 8'hFA || b == 8'hFE) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // One received byte outside WAIT, then the strobe drops
    task automatic send_byte(input logic [7:0] b, input bit err, input bit push);
        @(posedge clk); #1;
        host_rcv_strobe = 1'b1;
        host_rcv_data = b;
        host_rcv_error = err;
        tb_push = push;
        @(posedge clk); #1;
        host_rcv_strobe = 1'b0;
        host_rcv_error = 1'b0;
        tb_push = 0;
    endtask

    // Issue one command and play the keyboard from resp_q.
    // inj: 0 none, -1 random scancode in WAIT, >0 fixed 0x1C offset after first strobe
    task automatic run_cmd(input logic [7:0] op, input bit has_arg, input logic [7:0] arg,
                           input int inj, output int n_strb, output logic [1:0] err,
                           output int strb_cyc, output int done_cyc);
        int cyc, resp_at, inj_at, ri, r, resp_val, exp_n;
        bit fin;
        logic [7:0] inj_byte;
        model_cmd(op, has_arg, arg);
        exp_n = xmt_exp_q.size();
        n_strb = 0; err = 2'b11; strb_cyc = -1; done_cyc = -1;
        fin = 0; ri = 0; resp_at = -1; inj_at = -1; cyc = 0; resp_val = 0; inj_byte = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = op; cmd_has_arg = has_arg; cmd_arg = arg;
        @(negedge clk);
        chk("cmd_ready_at_accept", cmd_ready, 1);
        while (!fin && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            cmd_valid = 1'b0;
            host_rcv_strobe = 1'b0; host_rcv_error = 1'b0; tb_push = 0;
            if (cyc == inj_at) begin
                host_rcv_strobe = 1'b1; host_rcv_data = inj_byte; tb_push = 1;
            end else if (cyc == resp_at) begin
                host_rcv_strobe = 1'b1;
                if (resp_val == R_ERR) begin
                    host_rcv_error = 1'b1;
                    host_rcv_data = 8'($urandom_range(0, 255));
                end else begin
                    host_rcv_data = 8'(resp_val);
                end
            end
            @(negedge clk);
            if (host_xmt_strobe) begin
                n_strb++;
                if (strb_cyc < 0) strb_cyc = cyc;
                if (xmt_exp_q.size() > 0) chk("xmt_data", host_xmt_data, xmt_exp_q.pop_front());
                r = (ri < resp_q.size()) ? resp_q[ri] : -1;
                ri++;
                if (r >= 0) begin
                    resp_at = cyc + $urandom_range(1, 4);
                    resp_val = r;
                end else begin
                    resp_at = -1;
                end
                if (inj < 0 && resp_at - cyc >= 2) begin
                    inj_at = cyc + 1;
                    inj_byte = pick_sc();
                end else if (inj > 0 && n_strb == 1) begin
                    inj_at = cyc + inj;
                    inj_byte = 8'h1C;
                end
            end
            if (cmd_done) begin
                fin = 1;
                err = err_code;
                done_cyc = cyc;
            end
        end
        chk("cmd_done_seen", fin, 1);
        chk("xmt_count", n_strb, exp_n);
        if (fin) chk("err_code", err, exp_err);
    endtask

    initial begin
        int n, e_cyc, s_cyc, d_cyc, dsnap;
        logic [1:0] err;

        // Reset values while reset is held
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cmd_done", cmd_done, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_sc_valid", sc_valid, 0);
        chk("rst_sc_data", sc_data, 8'h00);
        chk("rst_sc_overflow", sc_overflow, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_xmt_strobe", host_xmt_strobe, 0);
        chk("rst_xmt_data", host_xmt_data, 8'h00);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        chk_en = 1;

        // FIFO fill past depth with no pops, then drain and clear overflow
        for (int v = 8'h10; v <= 8'h14; v++) send_byte(8'(v), 1'b0, 1'b1);
        @(negedge clk);
        chk("fifo_ovf_set", sc_overflow, 1);
        chk("fifo_full_head", sc_data, 8'h10);
        pop_mode = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fifo_pop_order", sc_data, 8'h10 + 8'(i));
            @(posedge clk); #1; sc_ready = 1'b1;
            @(posedge clk); #1; sc_ready = 1'b0;
        end
        @(negedge clk);
        chk("fifo_drained", sc_valid, 0);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        chk("fifo_ovf_cleared", sc_overflow, 0);

        // Directed commands
        ready_mode = 2;
        pop_mode = 1;
        resp_q = '{32'hFA};
        run_cmd(8'hF4, 1'b0, 8'h00, 0, n, err, s_cyc, d_cyc);
        chk("f4_ack_strobes", n, 1);
        chk("f4_ack_err", err, 0);

        resp_q = '{32'hFA, 32'hFA};
        run_cmd(8'hED, 1'b1, 8'h07, 0, n, err, s_cyc, d_cyc);
        chk("ed07_strobes", n, 2);
        chk("ed07_err", err, 0);

        resp_q = '{32'hFE, 32'hFE, 32'hFE, 32'hFE};
        run_cmd(8'hF4, 1'b0, 8'h00, 0, n, err, s_cyc, d_cyc);
        chk("resend4_strobes", n, 4);
        chk("resend4_err", err, 2);

        resp_q = '{32'hFE, 32'hFE, 32'hFA};
        run_cmd(8'hF4, 1'b0, 8'h00, 0, n, err, s_cyc, d_cyc);
        chk("resend2_strobes", n, 3);
        chk("resend2_err", err, 0);

        resp_q = '{R_ERR, 32'hFA};
        run_cmd(8'hF4, 1'b0, 8'h00, -1, n, err, s_cyc, d_cyc);
        chk("rxerr_retry_strobes", n, 2);
        chk("rxerr_retry_err", err, 0);

        // Response timeout with a scancode arriving mid-wait
        pop_mode = 3;
        repeat (8) @(posedge clk);
        pop_mode = 0;
        ready_mode = 1;
        resp_q.delete();
        run_cmd(8'hF4, 1'b0, 8'h00, 50, n, err, s_cyc, d_cyc);
        chk("to_err", err, 1);
        chk("to_first_strobe_latency", s_cyc, 1);
        chk("to_done_after_strobe", d_cyc - s_cyc, 101);
        @(negedge clk);
        chk("to_scancode_valid", sc_valid, 1);
        chk("to_scancode_data", sc_data, 8'h1C);

        // Host never ready: timeout from SEND with no strobe
        ready_mode = 0;
        run_cmd(8'hF4, 1'b0, 8'h00, 0, n, err, s_cyc, d_cyc);
        chk("send_to_strobes", n, 0);
        chk("send_to_err", err, 1);

        // Asynchronous reset in WAIT with a non-empty FIFO
        ready_mode = 1;
        send_byte(8'h55, 1'b0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = 8'hF4; cmd_has_arg = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_wait_state", dbg_state, 2);
        dsnap = done_cnt;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_cmd_done", cmd_done, 0);
        chk("arst_err_code", err_code, 0);
        chk("arst_sc_valid", sc_valid, 0);
        chk("arst_sc_data", sc_data, 8'h00);
        chk("arst_sc_overflow", sc_overflow, 0);
        chk("arst_xmt_strobe", host_xmt_strobe, 0);
        chk("arst_xmt_data", host_xmt_data, 8'h00);
        chk("arst_rx_err", rx_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_done", done_cnt, dsnap);
        chk("arst_idle_after", cmd_ready, 1);

        // Randomized commands with idle scancode traffic
        ready_mode = 2;
        pop_mode = 1;
        ovf_rand = 1;
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 4) == 0) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                else send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1);
            end
            resp_q.delete();
            for (int j = 0; j < 8; j++) begin
                e_cyc = $urandom_range(0, 99);
                if (e_cyc < 55) resp_q.push_back(32'hFA);
                else if (e_cyc < 75) resp_q.push_back(32'hFE);
                else if (e_cyc < 95) resp_q.push_back(R_ERR);
                else resp_q.push_back(-1);
            end
            run_cmd(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 1) == 1) ? -1 : 0, n, err, s_cyc, d_cyc);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
